// File: rtl/temp_hyst_monitor_if.sv
// temp_hyst_monitor_if: sample/threshold inputs and warning outputs of the
// multi-channel temperature hysteresis monitor. The master drives samples and
// thresholds; the slave (the monitor) drives warning state back.
interface temp_hyst_monitor_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int COUNT_W = $clog2(CHANNELS + 1);

  logic                      sample_valid;
  logic [CHANNELS*WIDTH-1:0] temp_in;
  logic [WIDTH-1:0]          temp_high;
  logic [WIDTH-1:0]          temp_low;
  logic                      alarm_clear;
  logic [CHANNELS-1:0]       warn;
  logic                      warn_any;
  logic [COUNT_W-1:0]        warn_count;
  logic                      warn_event;
  logic [CHANNELS-1:0]       alarm_sticky;

  modport master (
    output sample_valid, temp_in, temp_high, temp_low, alarm_clear,
    input  warn, warn_any, warn_count, warn_event, alarm_sticky
  );

  modport slave (
    input  sample_valid, temp_in, temp_high, temp_low, alarm_clear,
    output warn, warn_any, warn_count, warn_event, alarm_sticky
  );
endinterface

// File: rtl/temp_hyst_monitor.sv
// temp_hyst_monitor: per-channel IDLE/WARN hysteresis FSM with a debounce
// counter. A channel enters WARN after DEBOUNCE consecutive valid samples
// above temp_high and leaves it after DEBOUNCE consecutive valid samples below
// temp_low. Invalid cycles neither advance nor break a run.
// Optional feature: define TEMP_STICKY_EN to build the per-channel sticky
// alarm history (cleared by alarm_clear; a new WARN entry wins over a clear).
module temp_hyst_monitor #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  temp_hyst_monitor_if.slave   bus
);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);
  localparam int COUNT_W = $clog2(CHANNELS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic {IDLE = 1'b0, WARN = 1'b1} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] hot;
  logic [CHANNELS-1:0] cold;
  logic [CHANNELS-1:0] enter_warn;
  logic [CHANNELS-1:0] warn_vec;
  logic [COUNT_W-1:0]  warn_total;
  logic                event_q;

  // Strict unsigned threshold compares against the live thresholds.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hot[i]  = bus.temp_in[i*WIDTH +: WIDTH] > bus.temp_high;
      cold[i] = bus.temp_in[i*WIDTH +: WIDTH] < bus.temp_low;
    end
  end

  // Next state and debounce count per channel; flags IDLE->WARN entries.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every output gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      enter_warn[i] = 1'b0;
      if (bus.sample_valid) begin
        case (state_q[i])
          IDLE: begin
            if (!hot[i]) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i]    = WARN;
              cnt_d[i]      = '0;
              enter_warn[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          WARN: begin
            if (!cold[i]) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // State and count registers; reset discards any partial debounce run.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: these per-channel arrays are a few flops each, not a RAM, so they
      // take a reset like any other control state.
      if (reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // One-cycle event after any channel enters WARN; exits do not pulse.
  always_ff @(posedge clk) begin
    if (reset) event_q <= 1'b0;
    else       event_q <= |enter_warn;
  end

  // Per-channel warning view and its population count.
  always_comb begin
    warn_total = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      warn_vec[i] = (state_q[i] == WARN);
      if (warn_vec[i]) warn_total = warn_total + COUNT_W'(1);
    end
  end

  assign bus.warn       = warn_vec;
  assign bus.warn_any   = |warn_vec;
  assign bus.warn_count = warn_total;
  assign bus.warn_event = event_q;

`ifdef TEMP_STICKY_EN
  logic [CHANNELS-1:0] sticky_q;

  // Sticky history: a clear drops old bits, a fresh WARN entry sets its bit.
  always_ff @(posedge clk) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= (bus.alarm_clear ? '0 : sticky_q) | enter_warn;
  end

  assign bus.alarm_sticky = sticky_q;
`else
  // Without sticky history the clear input has no effect.
  logic unused_alarm_clear;
  assign unused_alarm_clear = bus.alarm_clear;
  assign bus.alarm_sticky   = '0;
`endif
endmodule

// File: tb/tb_temp_hyst_monitor.sv
// tb_temp_hyst_monitor: directed scenarios with literal expectations, then
// randomized stimulus, all compared every cycle against a run-length model.
module tb_temp_hyst_monitor;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int D  = 4;
  localparam int N  = 90;  // neutral temperature between the default thresholds

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  temp_hyst_monitor_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  temp_hyst_monitor #(.WIDTH(W), .CHANNELS(CH), .DEBOUNCE(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [CH*W-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  // Behavioural model: length of the current run of qualifying valid samples
  // per channel; a run reaching D flips the warning and starts over.
  bit          m_warn [CH];
  int          m_run  [CH];
  bit          m_event;
  logic [CH-1:0] m_sticky;

  always @(posedge clk) begin : model
    logic [CH-1:0] entered;
    int            t;
    bit            qual;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_warn[c] = 1'b0;
        m_run[c]  = 0;
      end
      m_event  = 1'b0;
      m_sticky = '0;
    end else begin
      entered = '0;
      for (int c = 0; c < CH; c++) begin
        if (bus.sample_valid) begin
          t    = int'(bus.temp_in[c*W +: W]);
          qual = m_warn[c] ? (t < int'(bus.temp_low)) : (t > int'(bus.temp_high));
          m_run[c] = qual ? m_run[c] + 1 : 0;
          if (m_run[c] == D) begin
            m_run[c]  = 0;
            m_warn[c] = !m_warn[c];
            if (m_warn[c]) entered[c] = 1'b1;
          end
        end
      end
      m_event = |entered;
`ifdef TEMP_STICKY_EN
      m_sticky = (bus.alarm_clear ? '0 : m_sticky) | entered;
`else
      m_sticky = '0;
`endif
    end
  end

  // Compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin : compare
    logic [CH-1:0] exp_warn;
    int            exp_cnt;
    exp_cnt = 0;
    for (int c = 0; c < CH; c++) begin
      exp_warn[c] = m_warn[c];
      exp_cnt += int'(m_warn[c]);
    end
    check("warn",         bus.warn,         exp_warn);
    check("warn_any",     bus.warn_any,     |exp_warn);
    check("warn_count",   bus.warn_count,   exp_cnt);
    check("warn_event",   bus.warn_event,   m_event);
    check("alarm_sticky", bus.alarm_sticky, m_sticky);
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic step(input logic [CH*W-1:0] temps, input bit v);
    bus.temp_in      = temps;
    bus.sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  int lvl [CH];

  initial begin
    bus.sample_valid = 1'b0;
    bus.temp_in      = pk(N, N, N, N);
    bus.temp_high    = W'(100);
    bus.temp_low     = W'(80);
    bus.alarm_clear  = 1'b0;
    reset            = 1'b1;
    step(pk(N, N, N, N), 0);
    step(pk(N, N, N, N), 0);
    reset = 1'b0;
    check("reset_warn",   bus.warn,         4'h0);
    check("reset_count",  bus.warn_count,   0);
    check("reset_event",  bus.warn_event,   1'b0);
    check("reset_sticky", bus.alarm_sticky, 4'h0);

    // ch0 hot for D valid samples
    repeat (3) step(pk(101, N, N, N), 1);
    check("hot3_no_warn", bus.warn, 4'h0);
    step(pk(101, N, N, N), 1);
    check("hot4_warn",  bus.warn,       4'h1);
    check("hot4_event", bus.warn_event, 1'b1);
    check("hot4_count", bus.warn_count, 1);
    check("hot4_any",   bus.warn_any,   1'b1);
    step(pk(101, N, N, N), 1);
    check("event_one_cycle", bus.warn_event, 1'b0);
    repeat (4) step(pk(79, N, N, N), 1);
    check("back_idle", bus.warn, 4'h0);

    // broken run does not warn; a full fresh run does
    step(pk(101, N, N, N), 1); step(pk(101, N, N, N), 1); step(pk(101, N, N, N), 1);
    step(pk(99,  N, N, N), 1);
    step(pk(101, N, N, N), 1); step(pk(101, N, N, N), 1); step(pk(101, N, N, N), 1);
    check("broken_run", bus.warn, 4'h0);
    step(pk(101, N, N, N), 1);
    check("fresh_run", bus.warn, 4'h1);

    // equality with temp_low holds WARN
    repeat (10) step(pk(80, N, N, N), 1);
    check("eq_low_hold", bus.warn, 4'h1);

    // cold samples separated by invalid gaps still form a run
    for (int k = 0; k < 4; k++) begin
      step(pk(79, N, N, N), 1);
      if (k == 2) check("gap_still_warn", bus.warn, 4'h1);
      if (k < 3) repeat (3) step(pk(200, N, N, N), 0);
    end
    check("gap_release", bus.warn,       4'h0);
    check("exit_no_event", bus.warn_event, 1'b0);

    // all channels enter together: one event
    repeat (4) step(pk(120, 120, 120, 120), 1);
    check("all_warn",  bus.warn,       4'hF);
    check("all_count", bus.warn_count, 4);
    check("all_event", bus.warn_event, 1'b1);
    step(pk(120, 120, 120, 120), 0);
    check("all_event_single", bus.warn_event, 1'b0);
    repeat (4) step(pk(60, 60, 60, 60), 1);
    check("all_idle", bus.warn, 4'h0);

`ifdef TEMP_STICKY_EN
    check("sticky_all", bus.alarm_sticky, 4'hF);
    bus.alarm_clear = 1'b1;
    step(pk(N, N, N, N), 0);
    bus.alarm_clear = 1'b0;
    check("sticky_cleared", bus.alarm_sticky, 4'h0);
    repeat (4) step(pk(N, N, 120, N), 1);
    check("sticky_ch2_set", bus.alarm_sticky, 4'h4);
    repeat (4) step(pk(N, N, 60, N), 1);
    check("ch2_idle", bus.warn, 4'h0);
    check("sticky_ch2_hold", bus.alarm_sticky, 4'h4);
    repeat (3) step(pk(N, 120, N, N), 1);
    bus.alarm_clear = 1'b1;
    step(pk(N, 120, N, N), 1);
    bus.alarm_clear = 1'b0;
    check("set_beats_clear", bus.alarm_sticky, 4'h2);
    check("ch1_warn", bus.warn, 4'h2);
    repeat (4) step(pk(N, 60, N, N), 1);
`else
    bus.alarm_clear = 1'b1;
    step(pk(N, N, N, N), 0);
    bus.alarm_clear = 1'b0;
    check("sticky_tied_low", bus.alarm_sticky, 4'h0);
`endif

    // reset discards a partial run on ch3
    repeat (3) step(pk(N, N, N, 101), 1);
    reset = 1'b1;
    step(pk(N, N, N, 101), 1);
    reset = 1'b0;
    check("reset_mid_warn", bus.warn, 4'h0);
    repeat (3) step(pk(N, N, N, 101), 1);
    check("post_reset_3", bus.warn, 4'h0);
    step(pk(N, N, N, 101), 1);
    check("post_reset_4", bus.warn, 4'h8);

    // randomized phase: persistent per-channel levels near the thresholds
    for (int c = 0; c < CH; c++) lvl[c] = N;
    for (int it = 0; it < 3000; it++) begin
      logic [CH*W-1:0] temps;
      if ($urandom_range(0, 59) == 0) begin
        bus.temp_high = W'($urandom_range(85, 105));
        bus.temp_low  = W'($urandom_range(70, 95));
      end
      bus.alarm_clear = ($urandom_range(0, 9) == 0);
      reset           = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) lvl[c] = int'($urandom_range(65, 115));
        temps[c*W +: W] = W'(lvl[c]);
      end
      step(temps, $urandom_range(0, 3) != 0);
    end
    reset           = 1'b0;
    bus.alarm_clear = 1'b0;
    repeat (3) step(pk(N, N, N, N), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
